// File: rtl/manchester_codec_p_pkg.sv
// Shared types and helpers for the parametrised Manchester codec.
//   tx_state_t  : encoder FSM states (idle, sending a frame, inter-frame gap)
//   rx_state_t  : decoder FSM states (idle, receiving, one-cycle word delivery)
//   frame_bits  : bits per frame = start + payload + optional parity
//   calc_parity : parity bit over a zero-extended payload word
package manchester_pkg;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_SEND,
    TX_GAP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_RECV,
    RX_DONE
  } rx_state_t;

  function automatic int frame_bits(input int data_w, input int parity_en);
    return 1 + data_w + ((parity_en != 0) ? 1 : 0);
  endfunction

  // Zero-extension of the payload does not change its XOR.
  function automatic logic calc_parity(input logic [31:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/manchester_codec_p_if.sv
// Host-side and line-side signal bundle of the Manchester codec.
//   tx_data/tx_valid/tx_ready : encoder write handshake
//   mdo / mdi                 : serial line out (registered) / in (asynchronous)
//   rx_data/rx_valid/rx_rd    : decoder read holding register and read strobe
//   rx_parity_err/rx_code_err/rx_overrun : decoder status flags
// modport slave is the codec side, modport master the host/line side.
interface manchester_codec_p_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              mdo;
  logic              mdi;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_rd;
  logic              rx_parity_err;
  logic              rx_code_err;
  logic              rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_rd, mdi,
    input  tx_ready, mdo, rx_data, rx_valid, rx_parity_err, rx_code_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_rd, mdi,
    output tx_ready, mdo, rx_data, rx_valid, rx_parity_err, rx_code_err, rx_overrun
  );
endinterface

// File: rtl/manchester_codec_p_rx.sv
// Manchester decoder.
//   clk16x, rst     : codec clock, sync active-high reset
//   mdi             : asynchronous line input
//   rx_data         : last delivered word; rx_valid marks it unread
//   rx_rd           : read strobe, clears rx_valid and rx_overrun
//   rx_parity_err   : parity status of the word in rx_data
//   rx_code_err     : one-cycle pulse when a bit has no mid-bit transition
//   rx_overrun      : sticky, a word arrived while rx_valid was still set
// Timing is free-running from the start-bit mid transition; there is no
// phase tracking inside a frame.
module manchester_rx_p
  import manchester_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OSR        = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk16x,
  input  logic              rst,
  input  logic              mdi,
  input  logic              rx_rd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_parity_err,
  output logic              rx_code_err,
  output logic              rx_overrun
);

  localparam int NB   = frame_bits(DATA_W, PARITY_EN);
  localparam int RW   = NB - 1;
  localparam int PH_W = $clog2(OSR);
  localparam int RB_W = $clog2(NB);

  localparam logic [PH_W-1:0] PH_LAST  = PH_W'(OSR - 1);
  localparam logic [PH_W-1:0] PH_START = PH_W'(OSR / 2 + 1);
  localparam logic [PH_W-1:0] PH_A     = PH_W'(OSR / 4);
  localparam logic [PH_W-1:0] PH_B     = PH_W'(3 * OSR / 4);
  localparam logic [RB_W-1:0] RB_LAST  = RB_W'(NB - 2);

  rx_state_t         state;
  logic              mdi_p0, mdi_p1, mdi_p2;
  logic [PH_W-1:0]   ph;
  logic [RB_W-1:0]   rbit;
  logic              a_seen;
  logic              a_smp;
  logic [RW-1:0]     shreg;
  logic              rise;
  logic              b_hit;
  logic [DATA_W-1:0] word;
  logic              perr;

  // p0/p1: synchroniser; p2: previous synchronised value for edge detect
  always_ff @(posedge clk16x) begin
    if (rst) begin
      mdi_p0 <= 1'b0;
      mdi_p1 <= 1'b0;
      mdi_p2 <= 1'b0;
    end else begin
      mdi_p0 <= mdi;
      mdi_p1 <= mdi_p0;
      mdi_p2 <= mdi_p1;
    end
  end

  assign rise  = mdi_p1 & ~mdi_p2;
  // The first PH_B after the start edge falls inside the start bit; a_seen
  // masks it so B is always paired with the A of the same bit.
  assign b_hit = (state == RX_RECV) && (ph == PH_B) && a_seen;
  assign word  = shreg[RW-1 -: DATA_W];
  assign perr  = (PARITY_EN != 0) ? ((^shreg) != (PARITY_ODD != 0)) : 1'b0;

  // ph = (cycles since start edge + OSR/2) mod OSR, i.e. position in the
  // current data bit, so A and B fall on fixed phase values.
  always_ff @(posedge clk16x) begin
    if (rst) begin
      state         <= RX_IDLE;
      ph            <= '0;
      rbit          <= '0;
      a_seen        <= 1'b0;
      a_smp         <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_code_err   <= 1'b0;
      rx_overrun    <= 1'b0;
    end else begin
      rx_code_err <= 1'b0;
      if (rx_rd && rx_valid) begin
        rx_valid   <= 1'b0;
        rx_overrun <= 1'b0;
      end
      case (state)
        RX_IDLE: begin
          if (rise) begin
            state  <= RX_RECV;
            ph     <= PH_START;
            rbit   <= '0;
            a_seen <= 1'b0;
          end
        end
        RX_RECV: begin
          ph <= (ph == PH_LAST) ? '0 : ph + 1'b1;
          if (ph == PH_A) begin
            a_smp  <= mdi_p1;
            a_seen <= 1'b1;
          end
          if (b_hit) begin
            if (a_smp == mdi_p1) begin
              rx_code_err <= 1'b1;
              state       <= RX_IDLE;
            end else if (rbit == RB_LAST) begin
              state <= RX_DONE;
            end else begin
              rbit <= rbit + 1'b1;
            end
          end
        end
        RX_DONE: begin
          state <= RX_IDLE;
          if (!rx_valid || rx_rd) begin
            rx_data       <= word;
            rx_parity_err <= perr;
            rx_valid      <= 1'b1;
          end else begin
            rx_overrun <= 1'b1;
          end
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk16x) begin
    if (b_hit) shreg <= (shreg << 1) | RW'(mdi_p1);
  end

endmodule

// File: rtl/manchester_codec_p_tx.sv
// Manchester encoder.
//   clk16x, rst        : codec clock (OSR x bit rate), sync active-high reset
//   tx_data, tx_valid  : word to send and write request
//   tx_ready           : high only in IDLE; one word accepted per frame
//   mdo                : registered line output, idle low
// A frame is start '1', payload MSB first, optional parity. Each bit is
// OSR clocks: complement of the bit for the first half, the bit itself for
// the second. After the frame mdo is held low for IDLE_BITS bit-times.
module manchester_tx_p
  import manchester_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OSR        = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int IDLE_BITS  = 2
) (
  input  logic              clk16x,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              mdo
);

  localparam int NB      = frame_bits(DATA_W, PARITY_EN);
  localparam int GAP_LEN = IDLE_BITS * OSR;
  localparam int CNT_W   = $clog2(OSR);
  localparam int BIT_W   = $clog2(NB);
  localparam int GAP_W   = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OSR / 2 - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NB - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_LEN - 1);

  tx_state_t         state;
  logic [CNT_W-1:0]  cnt;
  logic [BIT_W-1:0]  bidx;
  logic [GAP_W-1:0]  gcnt;
  logic [NB-1:0]     sh;
  logic              par;
  logic [DATA_W+1:0] full_word;
  logic              accept;

  assign par       = calc_parity(32'(tx_data), PARITY_ODD != 0);
  // Without parity the top NB bits of {start, data, parity} are the frame.
  assign full_word = {1'b1, tx_data, par};
  assign accept    = (state == TX_IDLE) && tx_valid && tx_ready;

  // cnt is the clock index within the bit currently shown on mdo, so mdo
  // is always set one clock ahead from the bit at the top of sh.
  always_ff @(posedge clk16x) begin
    if (rst) begin
      state    <= TX_IDLE;
      tx_ready <= 1'b1;
      mdo      <= 1'b0;
      cnt      <= '0;
      bidx     <= '0;
      gcnt     <= '0;
    end else begin
      case (state)
        TX_IDLE: begin
          if (accept) begin
            state    <= TX_SEND;
            tx_ready <= 1'b0;
            mdo      <= 1'b0;
            cnt      <= '0;
            bidx     <= '0;
          end
        end
        TX_SEND: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bidx == BIT_LAST) begin
              mdo <= 1'b0;
              if (GAP_LEN == 0) begin
                state    <= TX_IDLE;
                tx_ready <= 1'b1;
              end else begin
                state <= TX_GAP;
                gcnt  <= '0;
              end
            end else begin
              bidx <= bidx + 1'b1;
              mdo  <= ~sh[NB-2];
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CNT_MID) mdo <= sh[NB-1];
          end
        end
        TX_GAP: begin
          if (gcnt == GAP_LAST) begin
            state    <= TX_IDLE;
            tx_ready <= 1'b1;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk16x) begin
    if (accept) sh <= full_word[DATA_W+1 -: NB];
    else if ((state == TX_SEND) && (cnt == CNT_LAST)) sh <= sh << 1;
  end

endmodule

// File: rtl/manchester_codec_p.sv
// Parametrised Manchester codec top: encoder and decoder side by side on
// one clock. No logic here beyond wiring.
//   clk16x : codec clock, OSR x bit rate
//   rst    : synchronous active-high reset
//   bus    : slave side of manchester_codec_p_if (tx handshake, line
//            pins, rx holding register and flags)
module manchester_codec_p
  import manchester_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int OSR        = 16,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int IDLE_BITS  = 2
) (
  input  logic               clk16x,
  input  logic               rst,
  manchester_codec_p_if.slave bus
);

  manchester_tx_p #(
    .DATA_W    (DATA_W),
    .OSR       (OSR),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD),
    .IDLE_BITS (IDLE_BITS)
  ) u_tx (
    .clk16x  (clk16x),
    .rst     (rst),
    .tx_data (bus.tx_data),
    .tx_valid(bus.tx_valid),
    .tx_ready(bus.tx_ready),
    .mdo     (bus.mdo)
  );

  manchester_rx_p #(
    .DATA_W    (DATA_W),
    .OSR       (OSR),
    .PARITY_EN (PARITY_EN),
    .PARITY_ODD(PARITY_ODD)
  ) u_rx (
    .clk16x       (clk16x),
    .rst          (rst),
    .mdi          (bus.mdi),
    .rx_rd        (bus.rx_rd),
    .rx_data      (bus.rx_data),
    .rx_valid     (bus.rx_valid),
    .rx_parity_err(bus.rx_parity_err),
    .rx_code_err  (bus.rx_code_err),
    .rx_overrun   (bus.rx_overrun)
  );

endmodule

// File: tb/tb_manchester_codec_p.sv
// Self-checking bench for manchester_codec_p (8-bit, OSR 16, even parity).
module tb_manchester_codec_p;
  localparam int DATA_W     = 8;
  localparam int OSR        = 16;
  localparam int PARITY_EN  = 1;
  localparam int PARITY_ODD = 0;
  localparam int IDLE_BITS  = 2;
  localparam int NB         = 1 + DATA_W + PARITY_EN;
  localparam int GAP_LEN    = IDLE_BITS * OSR;

  typedef struct {
    logic [7:0] d;
    logic       perr;
  } rx_rec_t;

  typedef struct {
    logic [7:0] word;
    logic       flip;
    logic [7:0] exp_data;
    logic       exp_perr;
  } vec_t;

  logic clk16x = 1'b0;
  logic rst;
  logic loop_en;
  logic drv_mdi;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   code_err_pulses = 0;
  bit   auto_rd = 0;
  rx_rec_t rxq[$];

  always #5 clk16x = ~clk16x;

  manchester_codec_p_if #(.DATA_W(DATA_W)) bus ();
  assign bus.mdi = loop_en ? bus.mdo : drv_mdi;

  manchester_codec_p #(
    .DATA_W(DATA_W), .OSR(OSR), .PARITY_EN(PARITY_EN),
    .PARITY_ODD(PARITY_ODD), .IDLE_BITS(IDLE_BITS)
  ) dut (
    .clk16x(clk16x),
    .rst   (rst),
    .bus   (bus)
  );

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic raw_tick();
    @(posedge clk16x);
    #1;
    cyc++;
    if (bus.rx_code_err) code_err_pulses++;
  endtask

  // One clock; optionally drains the holding register into rxq.
  task automatic step();
    if (auto_rd && bus.rx_valid && !bus.rx_rd) begin
      rxq.push_back('{d: bus.rx_data, perr: bus.rx_parity_err});
      bus.rx_rd = 1'b1;
    end else begin
      bus.rx_rd = 1'b0;
    end
    raw_tick();
  endtask

  task automatic read_pulse();
    bus.rx_rd = 1'b1;
    raw_tick();
    bus.rx_rd = 1'b0;
  endtask

  function automatic logic par_of(input logic [7:0] w);
    return 1'((($countones(w)) + PARITY_ODD) % 2);
  endfunction

  // Line level at clock i of the frame carrying w.
  function automatic logic exp_mdo(input logic [7:0] w, input int i);
    logic [NB-1:0] bits;
    logic b;
    bits = {1'b1, w, par_of(w)};
    b = bits[NB-1-(i/OSR)];
    return ((i % OSR) >= OSR/2) ? b : ~b;
  endfunction

  task automatic drive_frame(input logic [7:0] w, input logic flip, input int bad_bit);
    logic [NB-1:0] bits;
    bits = {1'b1, w, par_of(w) ^ flip};
    for (int j = 0; j < NB; j++) begin
      if (j == bad_bit) begin
        drv_mdi = 1'b1;
        repeat (OSR) step();
        break;
      end
      drv_mdi = ~bits[NB-1-j];
      repeat (OSR/2) step();
      drv_mdi = bits[NB-1-j];
      repeat (OSR/2) step();
    end
    drv_mdi = 1'b0;
    repeat (GAP_LEN) step();
  endtask

  task automatic wait_rx_valid(input string name);
    int n = 0;
    while (!bus.rx_valid && n < 4*NB*OSR) begin
      step();
      n++;
    end
    check(name, bus.rx_valid, 1);
  endtask

  // Returns with the handshake done: current cycle shows first start clock.
  task automatic xmit(input logic [7:0] w, input bit hold);
    int n = 0;
    bus.tx_data  = w;
    bus.tx_valid = 1'b1;
    while (!bus.tx_ready && n < 1000) begin
      step();
      n++;
    end
    if (n >= 1000) check("xmit_ready_timeout", bus.tx_ready, 1);
    step();
    if (!hold) bus.tx_valid = 1'b0;
  endtask

  task automatic check_tx_frame(input logic [7:0] w, input string name);
    int nerr = 0;
    int low = 0;
    int n = 0;
    for (int i = 0; i < NB*OSR; i++) begin
      if (bus.mdo !== exp_mdo(w, i)) nerr++;
      if (!bus.tx_ready) low++;
      step();
    end
    while (!bus.tx_ready && n < 4*GAP_LEN + 10) begin
      if (bus.mdo !== 1'b0) nerr++;
      low++;
      step();
      n++;
    end
    check({name, "_mdo_errs"}, nerr, 0);
    check({name, "_ready_low"}, low, NB*OSR + GAP_LEN);
  endtask

  initial begin
    vec_t vecs[5];
    logic [7:0] expq[$];
    logic [7:0] w;
    int s1, s2, n, seen;

    rst          = 1'b1;
    loop_en      = 1'b1;
    drv_mdi      = 1'b0;
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_rd    = 1'b0;
    repeat (3) raw_tick();
    check("por_mdo", bus.mdo, 0);
    check("por_tx_ready", bus.tx_ready, 1);
    check("por_rx_valid", bus.rx_valid, 0);
    check("por_rx_data", bus.rx_data, 0);
    check("por_flags", {bus.rx_parity_err, bus.rx_code_err, bus.rx_overrun}, 0);
    rst = 1'b0;
    step();

    // Loopback 0xA5: waveform, busy window, received word.
    code_err_pulses = 0;
    xmit(8'hA5, 0);
    check_tx_frame(8'hA5, "a5");
    wait_rx_valid("a5_rx_valid");
    check("a5_rx_data", bus.rx_data, 8'hA5);
    check("a5_perr", bus.rx_parity_err, 0);
    check("a5_code_err", code_err_pulses, 0);

    // Reset in the middle of a frame, with 0xA5 still unread.
    xmit(8'h3C, 0);
    repeat (50) step();
    rst = 1'b1;
    repeat (3) raw_tick();
    check("rst_mdo", bus.mdo, 0);
    check("rst_tx_ready", bus.tx_ready, 1);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_flags", {bus.rx_parity_err, bus.rx_code_err, bus.rx_overrun}, 0);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (bus.rx_valid) seen++;
    end
    check("rst_aborted_no_rx", seen, 0);

    // Table-driven frames driven straight onto mdi.
    loop_en = 1'b0;
    vecs[0] = '{8'h3C, 1'b1, 8'h3C, 1'b1};
    vecs[1] = '{8'h3C, 1'b0, 8'h3C, 1'b0};
    vecs[2] = '{8'h01, 1'b0, 8'h01, 1'b0};
    vecs[3] = '{8'h80, 1'b1, 8'h80, 1'b1};
    vecs[4] = '{8'hFF, 1'b0, 8'hFF, 1'b0};
    for (int v = 0; v < 5; v++) begin
      drive_frame(vecs[v].word, vecs[v].flip, -1);
      wait_rx_valid($sformatf("vec%0d_valid", v));
      check($sformatf("vec%0d_data", v), bus.rx_data, vecs[v].exp_data);
      check($sformatf("vec%0d_perr", v), bus.rx_parity_err, vecs[v].exp_perr);
      read_pulse();
      check($sformatf("vec%0d_cleared", v), bus.rx_valid, 0);
    end

    // Overrun: two frames, no read in between.
    drive_frame(8'h11, 1'b0, -1);
    drive_frame(8'h22, 1'b0, -1);
    wait_rx_valid("ovr_valid");
    check("ovr_data_kept", bus.rx_data, 8'h11);
    check("ovr_flag", bus.rx_overrun, 1);
    read_pulse();
    check("ovr_rd_valid", bus.rx_valid, 0);
    check("ovr_rd_flag", bus.rx_overrun, 0);

    // Code violation in data bit 3, then a clean frame.
    code_err_pulses = 0;
    drive_frame(8'h5A, 1'b0, 4);
    repeat (2*OSR) step();
    check("cv_pulse_cycles", code_err_pulses, 1);
    check("cv_no_valid", bus.rx_valid, 0);
    drive_frame(8'h5A, 1'b0, -1);
    wait_rx_valid("cv_next_valid");
    check("cv_next_data", bus.rx_data, 8'h5A);
    check("cv_next_perr", bus.rx_parity_err, 0);
    read_pulse();

    // Back-to-back loopback with tx_valid held high.
    loop_en = 1'b1;
    auto_rd = 1;
    rxq.delete();
    xmit(8'h00, 1);
    s1 = cyc;
    bus.tx_data = 8'hFF;
    check_tx_frame(8'h00, "b2b0");
    step();
    s2 = cyc;
    bus.tx_valid = 1'b0;
    // 32 idle clocks after the frame, plus the handshake cycle.
    check("b2b_start_spacing", s2 - s1, NB*OSR + GAP_LEN + 1);
    check_tx_frame(8'hFF, "b2b1");
    n = 0;
    while (rxq.size() < 2 && n < 4*NB*OSR) begin
      step();
      n++;
    end
    check("b2b_rx_count", rxq.size(), 2);
    if (rxq.size() == 2) begin
      check("b2b_rx0", rxq[0].d, 8'h00);
      check("b2b_rx1", rxq[1].d, 8'hFF);
      check("b2b_perr", {rxq[0].perr, rxq[1].perr}, 0);
    end

    // Random loopback words against the bench's frame model.
    rxq.delete();
    code_err_pulses = 0;
    for (int r = 0; r < 10; r++) begin
      w = 8'($urandom);
      expq.push_back(w);
      xmit(w, 0);
      check_tx_frame(w, $sformatf("rnd%0d", r));
    end
    n = 0;
    while (rxq.size() < expq.size() && n < 4*NB*OSR) begin
      step();
      n++;
    end
    check("rnd_rx_count", rxq.size(), expq.size());
    for (int r = 0; r < expq.size() && r < rxq.size(); r++) begin
      check($sformatf("rnd%0d_rx", r), rxq[r].d, expq[r]);
      check($sformatf("rnd%0d_perr", r), rxq[r].perr, 0);
    end
    check("rnd_code_err", code_err_pulses, 0);
    check("rnd_overrun", bus.rx_overrun, 0);

    auto_rd = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
